// File: rtl/sumador_serial_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
package sumador_serial_ctrl_pkg;

    // FSM state encoding; 2'd3 is unused and falls back to idle.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

endpackage

// File: rtl/sumador_medio.sv
// One-bit half adder; two of these plus an OR make the serial full-adder cell.
module sumador_medio (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    // Sum and carry of two single bits.
    always_comb begin
        s = x ^ y;
        c = x & y;
    end

endmodule

// File: rtl/sumador_serial_ctrl.sv
// Bit-serial N-bit adder: one full-adder cell reused over N cycles, LSB first.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for start; sum/cout hold the last result
// ST_RUN   | one operand bit pair added per cycle, busy=1
// ST_FIN   | result complete, done=1 for this single cycle
module sumador_serial_ctrl
    import sumador_serial_ctrl_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  a_sh;
    logic [N-1:0]  b_sh;
    logic          carry;

    logic s_half;
    logic c_half;
    logic s_bit;
    logic c_prop;
    logic c_next;

    sumador_medio u_medio_ab (
        .x (a_sh[0]),
        .y (b_sh[0]),
        .s (s_half),
        .c (c_half)
    );

    sumador_medio u_medio_c (
        .x (s_half),
        .y (carry),
        .s (s_bit),
        .c (c_prop)
    );

    // Both half-adder carries can never be high together, so OR gives the majority.
    always_comb begin
        c_next = c_half | c_prop;
    end

    // FSM, bit counter, operand shifters, carry flop and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            cnt   <= '0;
            carry <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum   <= {s_bit, sum[N-1:1]};
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= c_next;
                    if (cnt == LAST) begin
                        cout  <= c_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_FIN;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_FIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
